// File: rtl/bcd_to_bin_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_if
// Handshake/data bundle for the sequential BCD-to-binary converter.
//
// Signals:
//   start  master->slave  request a conversion (sampled while busy=0)
//   bcd    master->slave  packed BCD word, digit NDIGITS-1 most significant
//   busy   slave->master  conversion in progress
//   done   slave->master  one-cycle pulse, result valid from this cycle on
//   bin    slave->master  binary result, held until the next accepted start
//   ovf    slave->master  result exceeded BINW bits (sticky per conversion)
//   err    slave->master  invalid digit (>9) seen (only with digit checking)
//
// Modports: master (requester / testbench side), slave (converter side).
// -----------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
  parameter int NDIGITS = 4,
  parameter int BINW    = 14
);
  logic                   start;
  logic [NDIGITS*4-1:0]   bcd;
  logic                   busy;
  logic                   done;
  logic [BINW-1:0]        bin;
  logic                   ovf;
  logic                   err;

  modport master (
    output start, bcd,
    input  busy, done, bin, ovf, err
  );

  modport slave (
    input  start, bcd,
    output busy, done, bin, ovf, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential BCD-to-binary converter. Consumes one BCD digit per clock,
// most-significant digit first, accumulating acc = acc*10 + digit.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   slave modport of bcd_to_bin_seq_if (start/bcd in;
//              busy/done/bin/ovf/err out)
//
// Parameters:
//   NDIGITS  number of BCD digits in the input word (>= 1)
//   BINW     binary result width; 2^BINW > 10^NDIGITS-1 for lossless results,
//            smaller widths wrap modulo 2^BINW and raise ovf
//
// Optional feature (compile-time macro BCD_TO_BIN_DIGIT_CHECK_EN):
//   defined   -> any digit > 9 seen during a conversion sets err (sticky
//                until the next accepted start); the digit is still
//                accumulated with its raw value
//   undefined -> err is tied low and no digit comparator is built
// -----------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int NDIGITS = 4,
  parameter int BINW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int BCDW = NDIGITS * 4;
  // Product acc*10 + 15 always fits in BINW+4 bits, so the top nibble is
  // exactly the overflow indicator.
  localparam int TW   = BINW + 4;
  localparam int CW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [BCDW-1:0]   sr_q;
  logic [CW-1:0]     cnt_q;
  logic [BINW-1:0]   bin_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic [3:0]        digit_d;
  logic [TW-1:0]     acc_d;

  // Current digit is always the top nibble; the register shifts left each step.
  assign digit_d = sr_q[BCDW-1 -: 4];

  // acc*10 as (acc<<3) + (acc<<1), widened before shifting so no bits are lost.
  assign acc_d = ({4'b0000, bin_q} << 3) + ({4'b0000, bin_q} << 1) + TW'(digit_d);

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  logic err_q;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          // DONE behaves like IDLE for acceptance, giving back-to-back starts.
          done_q <= 1'b0;
          if (bus.start) begin
            sr_q    <= bus.bcd;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_CONV: begin
          // start is ignored here: no queuing of requests.
          bin_q <= acc_d[BINW-1:0];
          if (acc_d[TW-1:BINW] != 4'b0000) begin
            ovf_q <= 1'b1;
          end
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
          if (digit_d > 4'd9) begin
            err_q <= 1'b1;
          end
`endif
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bin  = bin_q;
  assign bus.ovf  = ovf_q;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
// Directed testbench for bcd_to_bin_seq. Two instances: the default
// NDIGITS=4/BINW=14 build, and a narrow BINW=10 build for overflow cases.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.NDIGITS(4), .BINW(14)) bus  ();
  bcd_to_bin_seq_if #(.NDIGITS(4), .BINW(10)) bus2 ();

  bcd_to_bin_seq #(.NDIGITS(4), .BINW(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bcd_to_bin_seq #(.NDIGITS(4), .BINW(10)) dut_w10 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  localparam logic EXP_ERR_BAD_DIGIT = 1'b1;
`else
  localparam logic EXP_ERR_BAD_DIGIT = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge on the main instance, then wait (bounded) for done.
  // busy_cnt counts sampled cycles with busy=1, beginning right after the accept edge.
  task automatic run_conv(input logic [15:0] bcd, output int busy_cnt, output bit got_done);
    busy_cnt = 0;
    got_done = 1'b0;
    bus.bcd   = bcd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bcd   = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
  endtask

  task automatic run_conv_w10(input logic [15:0] bcd, output bit got_done);
    got_done = 1'b0;
    bus2.bcd   = bcd;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus2.done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;  bus.bcd = '0;
    bus2.start = 1'b0; bus2.bcd = '0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.bin !== 14'd0) begin n_bad++; $display("FAIL reset_bin got=%h exp=0", bus.bin); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_basic();
    int  bc;
    bit  gd;
    run_conv(16'h1234, bc, gd);
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL basic_done got=timeout exp=pulse"); end
    n_cmp++; if (bc !== 4) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    n_cmp++; if (bus.bin !== 14'h04D2) begin n_bad++; $display("FAIL basic_bin got=%h exp=04d2", bus.bin); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got=%b exp=0", bus.ovf); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b exp=0", bus.err); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got=%b exp=0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy got=%b exp=0", bus.busy); end
    tick();
    n_cmp++; if (bus.bin !== 14'h04D2) begin n_bad++; $display("FAIL basic_bin_hold got=%h exp=04d2", bus.bin); end
  endtask

  task automatic test_patterns();
    int  bc;
    bit  gd;
    run_conv(16'h9999, bc, gd);
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL max_done got=timeout exp=pulse"); end
    n_cmp++; if (bus.bin !== 14'h270F) begin n_bad++; $display("FAIL max_bin got=%h exp=270f", bus.bin); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL max_ovf got=%b exp=0", bus.ovf); end
    tick();
    run_conv(16'h0000, bc, gd);
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL zero_done got=timeout exp=pulse"); end
    n_cmp++; if (bc !== 4) begin n_bad++; $display("FAIL zero_busy_cycles got=%0d exp=4", bc); end
    n_cmp++; if (bus.bin !== 14'h0000) begin n_bad++; $display("FAIL zero_bin got=%h exp=0000", bus.bin); end
    tick();
    run_conv(16'h0507, bc, gd);
    n_cmp++; if (bus.bin !== 14'd507) begin n_bad++; $display("FAIL mid_bin got=%0d exp=507", bus.bin); end
    tick();
  endtask

  // start held high through CONV is ignored; held through DONE it is accepted.
  task automatic test_back_to_back();
    bit gd;
    int extra;
    bus.bcd   = 16'h0042;
    bus.start = 1'b1;
    tick();
    bus.bcd   = 16'h7777;
    gd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin gd = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL b2b_first_done got=timeout exp=pulse"); end
    n_cmp++; if (bus.bin !== 14'h002A) begin n_bad++; $display("FAIL b2b_ignore_bin got=%h exp=002a", bus.bin); end
    bus.bcd = 16'h0100;
    tick();
    bus.start = 1'b0;
    bus.bcd   = 16'h0000;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept_busy got=%b exp=1", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width got=%b exp=0", bus.done); end
    gd = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin gd = 1'b1; break; end
      extra++;
      tick();
    end
    n_cmp++; if (!gd || extra !== 4) begin n_bad++; $display("FAIL b2b_second_done got=%0d_cycles exp=4", extra); end
    n_cmp++; if (bus.bin !== 14'h0064) begin n_bad++; $display("FAIL b2b_second_bin got=%h exp=0064", bus.bin); end
    tick();
  endtask

  task automatic test_reset_mid();
    int  bc;
    bit  gd;
    bit  saw_done;
    bus.bcd   = 16'h5555;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.bin !== 14'd0) begin n_bad++; $display("FAIL rstmid_bin got=%h exp=0", bus.bin); end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_pulse got=1 exp=0"); end
    run_conv(16'h0007, bc, gd);
    n_cmp++; if (!gd || bus.bin !== 14'd7) begin n_bad++; $display("FAIL rstmid_restart got=%0d exp=7", bus.bin); end
    tick();
  endtask

  task automatic test_overflow();
    bit gd;
    run_conv_w10(16'h1234, gd);
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL ovf_done got=timeout exp=pulse"); end
    n_cmp++; if (bus2.bin !== 10'd210) begin n_bad++; $display("FAIL ovf_bin got=%0d exp=210", bus2.bin); end
    n_cmp++; if (bus2.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", bus2.ovf); end
    tick();
    run_conv_w10(16'h0010, gd);
    n_cmp++; if (bus2.bin !== 10'd10) begin n_bad++; $display("FAIL ovf_clear_bin got=%0d exp=10", bus2.bin); end
    n_cmp++; if (bus2.ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_flag got=%b exp=0", bus2.ovf); end
    tick();
  endtask

  // 1*1000 + 2*100 + 10*10 + 4 = 1304 = 0x0518 regardless of checking.
  task automatic test_digit_check();
    int  bc;
    bit  gd;
    run_conv(16'h12A4, bc, gd);
    n_cmp++; if (bus.bin !== 14'h0518) begin n_bad++; $display("FAIL digit_bin got=%h exp=0518", bus.bin); end
    n_cmp++; if (bus.err !== EXP_ERR_BAD_DIGIT) begin n_bad++; $display("FAIL digit_err got=%b exp=%b", bus.err, EXP_ERR_BAD_DIGIT); end
    tick();
    run_conv(16'h0311, bc, gd);
    n_cmp++; if (bus.err !== 1'b0 || bus.bin !== 14'd311) begin n_bad++; $display("FAIL digit_err_clear got=%b/%0d exp=0/311", bus.err, bus.bin); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_digit_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
